// File: rtl/alu_share_if.sv
// Request/response bundle between two issuing units and the shared ALU scheduler.
// Ports (signals):
//   req0_*/req1_* : valid/ready handshake plus operands a, b and 12-bit control word
//   resp_*        : result channel (valid/ready, 32-bit result, requester id)
// The master modport is the requester/consumer side; slave is the scheduler.
interface alu_share_if;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 12;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic [OP_W-1:0]   req0_op;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic [OP_W-1:0]   req1_op;

  logic              resp_valid;
  logic              resp_ready;
  logic [DATA_W-1:0] resp_result;
  logic              resp_id;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    input  req0_ready,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req1_ready,
    input  resp_valid, resp_result, resp_id,
    output resp_ready
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    output req0_ready,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req1_ready,
    output resp_valid, resp_result, resp_id,
    input  resp_ready
  );
endinterface

// File: rtl/alu_share_ctrl.sv
// Two-requester scheduler sharing one 32-bit ALU; one operation in flight at a time.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : alu_share_if.slave (two request ports, one tagged response port)
//   busy       : high whenever the scheduler is not idle
// Control word: {c_0, Const_Var, shift_direction, Function_class[1:0],
//                Logic_function[1:0], Const_amount[4:0]}, bit 11 = c_0.
module alu_share_ctrl #(
  parameter bit RR_ENABLE = 1'b1
) (
  input  logic          clk,
  input  logic          rst_n,
  alu_share_if.slave    bus,
  output logic          busy
);
  localparam int unsigned DATA_W = 32;
  localparam int unsigned OP_W   = 12;
  localparam int unsigned SH_W   = 5;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] a_q, b_q, result_q;
  logic [OP_W-1:0]   op_q;
  logic              id_q, last_grant_q, resp_valid_q, resp_id_q;

  logic              grant_c, idle_c, hs_c;
  logic [DATA_W-1:0] alu_s_c;

  // Arbitration: lone requester wins; on contention alternate or favour port 0.
  always_comb begin
    grant_c = 1'b0;
    if (bus.req0_valid && bus.req1_valid) begin
      grant_c = RR_ENABLE ? ~last_grant_q : 1'b0;
    end else if (bus.req1_valid) begin
      grant_c = 1'b1;
    end
  end

  assign idle_c         = (state_q == IDLE);
  assign bus.req0_ready = idle_c && !grant_c;
  assign bus.req1_ready = idle_c && grant_c;
  assign hs_c           = idle_c && (grant_c ? bus.req1_valid : bus.req0_valid);

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (hs_c) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, result capture and response flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      id_q         <= 1'b0;
      last_grant_q <= 1'b1;
      result_q     <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= 1'b0;
    end else begin
      if (hs_c) begin
        a_q          <= grant_c ? bus.req1_a  : bus.req0_a;
        b_q          <= grant_c ? bus.req1_b  : bus.req0_b;
        op_q         <= grant_c ? bus.req1_op : bus.req0_op;
        id_q         <= grant_c;
        last_grant_q <= grant_c;
      end
      if (state_q == EXEC) begin
        result_q     <= alu_s_c;
        resp_valid_q <= 1'b1;
        resp_id_q    <= id_q;
      end else if ((state_q == RESP) && bus.resp_ready) begin
        resp_valid_q <= 1'b0;
      end
    end
  end

  // Combinational ALU fed from the captured operands; c_0 is carry-in and subtract select.
  always_comb begin
    logic            c0, const_var, shift_left;
    logic [1:0]      fclass, lfunc;
    logic [SH_W-1:0] shamt;
    logic [DATA_W-1:0] b_eff, sum;
    c0         = op_q[11];
    const_var  = op_q[10];
    shift_left = op_q[9];
    fclass     = op_q[8:7];
    lfunc      = op_q[6:5];
    shamt      = const_var ? a_q[SH_W-1:0] : op_q[SH_W-1:0];
    b_eff      = c0 ? ~b_q : b_q;
    sum        = a_q + b_eff + DATA_W'(c0);
    alu_s_c    = '0;
    case (fclass)
      2'd0: alu_s_c = shift_left ? (b_q << shamt) : (b_q >> shamt);
      2'd1: alu_s_c = DATA_W'(sum[DATA_W-1]);
      2'd2: alu_s_c = sum;
      default: begin
        case (lfunc)
          2'd0:    alu_s_c = a_q & b_q;
          2'd1:    alu_s_c = a_q | b_q;
          2'd2:    alu_s_c = a_q ^ b_q;
          default: alu_s_c = ~(a_q | b_q);
        endcase
      end
    endcase
  end

  assign bus.resp_valid  = resp_valid_q;
  assign bus.resp_result = result_q;
  assign bus.resp_id     = resp_id_q;
  assign busy            = (state_q != IDLE);
endmodule

// File: tb/tb_alu_share_ctrl.sv
// Directed bench for alu_share_ctrl: a round-robin instance (dut0) and a fixed-priority
// instance (dut1) share one clock and reset.
module tb_alu_share_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy0, busy1;
  int n_cmp = 0;
  int n_err = 0;

  alu_share_if if0();
  alu_share_if if1();

  alu_share_ctrl #(.RR_ENABLE(1'b1)) dut0 (.clk(clk), .rst_n(rst_n), .bus(if0), .busy(busy0));
  alu_share_ctrl #(.RR_ENABLE(1'b0)) dut1 (.clk(clk), .rst_n(rst_n), .bus(if1), .busy(busy1));

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [11:0] mk_op(input logic c0, input logic cv, input logic dir,
                                        input logic [1:0] fc, input logic [1:0] lf,
                                        input logic [4:0] amt);
    return {c0, cv, dir, fc, lf, amt};
  endfunction

  task automatic idle_inputs();
    if0.req0_valid = 0; if0.req0_a = 0; if0.req0_b = 0; if0.req0_op = 0;
    if0.req1_valid = 0; if0.req1_a = 0; if0.req1_b = 0; if0.req1_op = 0;
    if0.resp_ready = 1;
    if1.req0_valid = 0; if1.req0_a = 0; if1.req0_b = 0; if1.req0_op = 0;
    if1.req1_valid = 0; if1.req1_a = 0; if1.req1_b = 0; if1.req1_op = 0;
    if1.resp_ready = 1;
  endtask

  task automatic do_reset();
    rst_n = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
  endtask

  task automatic drive_req(input bit p, input logic v, input logic [31:0] a,
                           input logic [31:0] b, input logic [11:0] op);
    if (p) begin
      if0.req1_valid = v; if0.req1_a = a; if0.req1_b = b; if0.req1_op = op;
    end else begin
      if0.req0_valid = v; if0.req0_a = a; if0.req0_b = b; if0.req0_op = op;
    end
  endtask

  // Issue one request on dut0 and return the response; lat counts cycles after the handshake.
  task automatic run_op(input bit p, input logic [31:0] a, input logic [31:0] b,
                        input logic [11:0] op, output logic [31:0] res, output logic id,
                        output int lat, output bit timeout);
    res = 'x; id = 1'bx; lat = 0;
    @(posedge clk); #1;
    drive_req(p, 1'b1, a, b, op);
    timeout = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (p ? if0.req1_ready : if0.req0_ready) begin timeout = 0; break; end
    end
    if (timeout) begin drive_req(p, 1'b0, 0, 0, 0); return; end
    @(posedge clk); #1;
    drive_req(p, 1'b0, 0, 0, 0);
    timeout = 1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      lat++;
      if (if0.resp_valid) begin timeout = 0; break; end
    end
    res = if0.resp_result;
    id  = if0.resp_id;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    n_cmp++; if (busy0 !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy0); end
    n_cmp++; if (if0.resp_valid !== 1'b0) begin n_err++; $display("FAIL reset_resp_valid: got %b want 0", if0.resp_valid); end
    n_cmp++; if (if0.resp_result !== 32'd0) begin n_err++; $display("FAIL reset_result: got %h want 0", if0.resp_result); end
    n_cmp++; if (if0.resp_id !== 1'b0) begin n_err++; $display("FAIL reset_id: got %b want 0", if0.resp_id); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(negedge clk);
    n_cmp++; if ({if0.req0_ready, if0.req1_ready} !== 2'b10) begin n_err++; $display("FAIL reset_ready: got %b want 10", {if0.req0_ready, if0.req1_ready}); end
  endtask

  task automatic test_port0();
    logic [31:0] r; logic id; int lat; bit to;
    run_op(1'b0, 32'd3, 32'd4, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0), r, id, lat, to);
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL p0_timeout: got %b want 0", to); end
    n_cmp++; if (r !== 32'd7) begin n_err++; $display("FAIL p0_add_result: got %0d want 7", r); end
    n_cmp++; if (id !== 1'b0) begin n_err++; $display("FAIL p0_id: got %b want 0", id); end
    n_cmp++; if (lat !== 2) begin n_err++; $display("FAIL p0_latency: got %0d want 2", lat); end
  endtask

  task automatic test_port1();
    logic [31:0] r; logic id; int lat; bit to;
    run_op(1'b1, 32'd10, 32'd5, mk_op(1, 0, 0, 2'd2, 2'd0, 5'd0), r, id, lat, to);
    n_cmp++; if ({to, r, id} !== {1'b0, 32'd5, 1'b1}) begin n_err++; $display("FAIL p1_sub: got to=%b r=%0d id=%b want to=0 r=5 id=1", to, r, id); end
    run_op(1'b1, 32'd2, 32'd5, mk_op(1, 0, 0, 2'd1, 2'd0, 5'd0), r, id, lat, to);
    n_cmp++; if ({to, r, id} !== {1'b0, 32'd1, 1'b1}) begin n_err++; $display("FAIL p1_slt: got to=%b r=%0d id=%b want to=0 r=1 id=1", to, r, id); end
  endtask

  task automatic test_shift_logic();
    logic [31:0] r; logic id; int lat; bit to;
    run_op(1'b0, 32'd6, 32'd123, mk_op(0, 1, 1, 2'd0, 2'd0, 5'd0), r, id, lat, to);
    n_cmp++; if ({to, r} !== {1'b0, 32'd7872}) begin n_err++; $display("FAIL shl_var: got to=%b r=%0d want 7872", to, r); end
    run_op(1'b0, 32'd0, 32'd321, mk_op(0, 0, 0, 2'd0, 2'd0, 5'd7), r, id, lat, to);
    n_cmp++; if ({to, r} !== {1'b0, 32'd2}) begin n_err++; $display("FAIL shr_const: got to=%b r=%0d want 2", to, r); end
    // 66 | 77 = 0x4F, so NOR gives 0xFFFFFFB0.
    run_op(1'b0, 32'd66, 32'd77, mk_op(0, 0, 0, 2'd3, 2'd3, 5'd0), r, id, lat, to);
    n_cmp++; if ({to, r} !== {1'b0, 32'hFFFF_FFB0}) begin n_err++; $display("FAIL nor: got to=%b r=%h want ffffffb0", to, r); end
    run_op(1'b0, 32'd66, 32'd77, mk_op(0, 0, 0, 2'd3, 2'd2, 5'd0), r, id, lat, to);
    n_cmp++; if ({to, r} !== {1'b0, 32'h0000_000F}) begin n_err++; $display("FAIL xor: got to=%b r=%h want 0000000f", to, r); end
  endtask

  task automatic test_round_robin();
    logic [3:0] exp_id;
    logic [31:0] res_q[$];
    logic id_q[$];
    exp_id = 4'b1010; // bit k = expected id of response k: 0,1,0,1
    do_reset();
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    drive_req(1'b1, 1'b1, 32'd10, 32'd1, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (if0.resp_valid && id_q.size() < 4) begin
        id_q.push_back(if0.resp_id);
        res_q.push_back(if0.resp_result);
      end
    end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 0, 0, 0);
    drive_req(1'b1, 1'b0, 0, 0, 0);
    n_cmp++; if (id_q.size() !== 4) begin n_err++; $display("FAIL rr_count: got %0d responses want 4", id_q.size()); end
    for (int k = 0; k < id_q.size(); k++) begin
      n_cmp++;
      if ({id_q[k], res_q[k]} !== {exp_id[k], exp_id[k] ? 32'd11 : 32'd2}) begin
        n_err++;
        $display("FAIL rr_order[%0d]: got id=%b r=%0d want id=%b r=%0d", k, id_q[k], res_q[k], exp_id[k], exp_id[k] ? 11 : 2);
      end
    end
  endtask

  task automatic test_fixed_priority();
    int n_resp, bad_id, starve;
    n_resp = 0; bad_id = 0; starve = 0;
    @(posedge clk); #1;
    if1.req0_valid = 1; if1.req0_a = 32'd1; if1.req0_b = 32'd1; if1.req0_op = mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0);
    if1.req1_valid = 1; if1.req1_a = 32'd9; if1.req1_b = 32'd9; if1.req1_op = mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (if1.req1_ready) starve++;
      if (if1.resp_valid) begin
        n_resp++;
        if (if1.resp_id !== 1'b0 || if1.resp_result !== 32'd2) bad_id++;
      end
    end
    @(posedge clk); #1;
    if1.req0_valid = 0; if1.req1_valid = 0;
    n_cmp++; if (n_resp < 4) begin n_err++; $display("FAIL fp_count: got %0d responses want >=4", n_resp); end
    n_cmp++; if (bad_id !== 0) begin n_err++; $display("FAIL fp_winner: got %0d non-port0 responses want 0", bad_id); end
    n_cmp++; if (starve !== 0) begin n_err++; $display("FAIL fp_starve: got %0d req1_ready cycles want 0", starve); end
  endtask

  task automatic test_back_to_back_backpressure();
    bit to;
    if0.resp_ready = 0;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd3, 32'd4, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    to = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (if0.req0_ready) begin to = 0; break; end end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 0, 0, 0);
    for (int i = 0; i < 20 && !to; i++) begin @(negedge clk); if (if0.resp_valid) break; if (i == 19) to = 1; end
    n_cmp++; if (to !== 1'b0) begin n_err++; $display("FAIL bp_timeout: got %b want 0", to); end
    drive_req(1'b1, 1'b1, 32'd10, 32'd5, mk_op(1, 0, 0, 2'd2, 2'd0, 5'd0));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({if0.resp_valid, if0.resp_result, if0.resp_id, if0.req1_ready} !== {1'b1, 32'd7, 1'b0, 1'b0}) begin
        n_err++;
        $display("FAIL bp_hold[%0d]: got v=%b r=%0d id=%b rdy1=%b want v=1 r=7 id=0 rdy1=0", i, if0.resp_valid, if0.resp_result, if0.resp_id, if0.req1_ready);
      end
    end
    @(posedge clk); #1;
    if0.resp_ready = 1;
    @(negedge clk);
    @(negedge clk);
    n_cmp++; if ({if0.resp_valid, if0.req1_ready} !== 2'b01) begin n_err++; $display("FAIL bp_release: got v=%b rdy1=%b want v=0 rdy1=1", if0.resp_valid, if0.req1_ready); end
    @(posedge clk); #1;
    drive_req(1'b1, 1'b0, 0, 0, 0);
    to = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (if0.resp_valid) begin to = 0; break; end end
    n_cmp++; if ({to, if0.resp_result, if0.resp_id} !== {1'b0, 32'd5, 1'b1}) begin n_err++; $display("FAIL bp_next: got to=%b r=%0d id=%b want to=0 r=5 id=1", to, if0.resp_result, if0.resp_id); end
  endtask

  task automatic test_reset_mid_exec();
    bit to; int spurious;
    spurious = 0;
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd3, 32'd4, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    to = 1;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (if0.req0_ready) begin to = 0; break; end end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 0, 0, 0);
    n_cmp++; if ({to, busy0} !== 2'b01) begin n_err++; $display("FAIL rst_exec_busy: got to=%b busy=%b want to=0 busy=1", to, busy0); end
    #2 rst_n = 0;
    #1;
    n_cmp++; if ({busy0, if0.resp_valid} !== 2'b00) begin n_err++; $display("FAIL rst_async: got busy=%b v=%b want 00", busy0, if0.resp_valid); end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    for (int i = 0; i < 4; i++) begin @(negedge clk); if (if0.resp_valid) spurious++; end
    n_cmp++; if (spurious !== 0) begin n_err++; $display("FAIL rst_no_resp: got %0d valid cycles want 0", spurious); end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b1, 32'd1, 32'd1, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    drive_req(1'b1, 1'b1, 32'd2, 32'd2, mk_op(0, 0, 0, 2'd2, 2'd0, 5'd0));
    @(negedge clk);
    n_cmp++; if ({if0.req0_ready, if0.req1_ready} !== 2'b10) begin n_err++; $display("FAIL rst_first_grant: got %b want 10", {if0.req0_ready, if0.req1_ready}); end
    @(posedge clk); #1;
    drive_req(1'b0, 1'b0, 0, 0, 0);
    drive_req(1'b1, 1'b0, 0, 0, 0);
    repeat (4) @(posedge clk);
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_port0();
    test_port1();
    test_shift_logic();
    test_round_robin();
    test_fixed_priority();
    test_back_to_back_backpressure();
    test_reset_mid_exec();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
